audio_nios_i2c_cfg_master: RTL and testbench

AUDIO_NIOS_I2C_CFG_MASTER -- requirements
Module: audio_nios_i2c_cfg_master

---
 rtl/audio_nios_i2c_cfg_master.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_audio_nios_i2c_cfg_master.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_nios_i2c_cfg_master.sv
// Avalon-MM I2C byte-level master for audio codec configuration.
// One CMD launches an optional START, one 9-bit byte slot and an optional STOP.
module audio_nios_i2c_cfg_master #(
    parameter logic [15:0] CLKDIV_RESET = 16'd125
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        scl_oe,
    output logic        sda_oe,
    input  logic        scl_in,
    input  logic        sda_in,
    output logic        irq
);

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_CMD    = 2'd1;
    localparam logic [1:0] ADDR_STATUS = 2'd2;
    localparam logic [1:0] ADDR_DIV    = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_BIT,
        S_STOP
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  quarter_q, quarter_d;
    logic [3:0]  bit_q, bit_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] div_q, div_d;
    logic [7:0]  data_q, data_d;
    logic [7:0]  tx_q, tx_d;
    logic [7:0]  rx_q, rx_d;
    logic        busy_q, busy_d;
    logic        ack_err_q, ack_err_d;
    logic        done_q, done_d;
    logic        start_q, start_d;
    logic        stop_q, stop_d;
    logic        read_q, read_d;
    logic        nack_q, nack_d;
    logic        scl_oe_q, scl_oe_d;
    logic        sda_oe_q, sda_oe_d;

    logic        wr_en;
    logic        cmd_acc;
    logic [15:0] div_eff;
    logic        stretch;
    logic        tick;
    logic [7:0]  tx_shift;
    logic        wdata_unused;

    assign wdata_unused = ^writedata[31:16];

    // SDA pull-down for quarter 0 of bit slot idx: data bits follow tx for a
    // write; the 9th slot is the master's ACK on a read, released on a write.
    function automatic logic bit_sda(input logic rd, input logic nk,
                                     input logic [3:0] idx, input logic txb);
        logic v;
        if (idx == 4'd8) begin
            v = rd & ~nk;
        end else begin
            v = ~rd & ~txb;
        end
        return v;
    endfunction

    assign wr_en    = chipselect & ~write_n;
    assign cmd_acc  = wr_en && (address == ADDR_CMD) && !busy_q;
    assign div_eff  = (div_q == 16'd0) ? 16'd1 : div_q;
    // A slave holding SCL low while we release it freezes the quarter timer.
    assign stretch  = (state_q != S_IDLE) && !scl_oe_q && !scl_in;
    assign tick     = (state_q != S_IDLE) && (cnt_q == 16'd0) && !stretch;
    assign tx_shift = {tx_q[6:0], 1'b0};

    always_comb begin
        state_d   = state_q;
        quarter_d = quarter_q;
        bit_d     = bit_q;
        cnt_d     = cnt_q;
        div_d     = div_q;
        data_d    = data_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        busy_d    = busy_q;
        ack_err_d = ack_err_q;
        done_d    = done_q;
        start_d   = start_q;
        stop_d    = stop_q;
        read_d    = read_q;
        nack_d    = nack_q;
        scl_oe_d  = scl_oe_q;
        sda_oe_d  = sda_oe_q;

        if (wr_en) begin
            case (address)
                ADDR_DATA: data_d = writedata[7:0];
                ADDR_STATUS: begin
                    if (writedata[1]) ack_err_d = 1'b0;
                    if (writedata[2]) done_d = 1'b0;
                end
                ADDR_DIV: begin
                    if (!busy_q) div_d = writedata[15:0];
                end
                default: ;
            endcase
        end

        if ((state_q != S_IDLE) && !stretch) begin
            cnt_d = (cnt_q == 16'd0) ? div_eff - 16'd1 : cnt_q - 16'd1;
        end

        // FSM events come after the STATUS write so a same-cycle done set wins.
        case (state_q)
            S_IDLE: begin
                if (cmd_acc) begin
                    busy_d    = 1'b1;
                    done_d    = 1'b0;
                    ack_err_d = 1'b0;
                    start_d   = writedata[0];
                    stop_d    = writedata[1];
                    read_d    = writedata[2];
                    nack_d    = writedata[3];
                    tx_d      = data_q;
                    cnt_d     = div_eff - 16'd1;
                    quarter_d = 2'd0;
                    bit_d     = 4'd0;
                    if (writedata[0]) begin
                        state_d  = S_START;
                        sda_oe_d = 1'b0;
                    end else begin
                        state_d  = S_BIT;
                        scl_oe_d = 1'b1;
                        sda_oe_d = bit_sda(writedata[2], writedata[3], 4'd0, data_q[7]);
                    end
                end
            end
            S_START: begin
                if (tick) begin
                    case (quarter_q)
                        2'd0: begin
                            quarter_d = 2'd1;
                            scl_oe_d  = 1'b0;
                            sda_oe_d  = 1'b0;
                        end
                        2'd1: begin
                            quarter_d = 2'd2;
                            sda_oe_d  = 1'b1;
                        end
                        default: begin
                            state_d   = S_BIT;
                            quarter_d = 2'd0;
                            bit_d     = 4'd0;
                            scl_oe_d  = 1'b1;
                            sda_oe_d  = bit_sda(read_q, nack_q, 4'd0, tx_q[7]);
                        end
                    endcase
                end
            end
            S_BIT: begin
                if (tick) begin
                    case (quarter_q)
                        2'd0: quarter_d = 2'd1;
                        2'd1: begin
                            quarter_d = 2'd2;
                            scl_oe_d  = 1'b0;
                        end
                        2'd2: begin
                            quarter_d = 2'd3;
                            if (bit_q != 4'd8) begin
                                if (read_q) rx_d = {rx_q[6:0], sda_in};
                            end else if (!read_q && sda_in) begin
                                ack_err_d = 1'b1;
                            end
                        end
                        default: begin
                            quarter_d = 2'd0;
                            scl_oe_d  = 1'b1;
                            if (bit_q == 4'd8) begin
                                if (stop_q) begin
                                    state_d  = S_STOP;
                                    sda_oe_d = 1'b1;
                                end else begin
                                    state_d  = S_IDLE;
                                    sda_oe_d = 1'b0;
                                    busy_d   = 1'b0;
                                    done_d   = 1'b1;
                                end
                            end else begin
                                bit_d    = bit_q + 4'd1;
                                tx_d     = tx_shift;
                                sda_oe_d = bit_sda(read_q, nack_q, bit_q + 4'd1, tx_shift[7]);
                            end
                        end
                    endcase
                end
            end
            S_STOP: begin
                if (tick) begin
                    case (quarter_q)
                        2'd0: begin
                            quarter_d = 2'd1;
                            scl_oe_d  = 1'b0;
                        end
                        2'd1: begin
                            quarter_d = 2'd2;
                            sda_oe_d  = 1'b0;
                        end
                        default: begin
                            state_d   = S_IDLE;
                            quarter_d = 2'd0;
                            busy_d    = 1'b0;
                            done_d    = 1'b1;
                        end
                    endcase
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            quarter_q <= 2'd0;
            bit_q     <= 4'd0;
            cnt_q     <= 16'd0;
            div_q     <= CLKDIV_RESET;
            data_q    <= 8'h00;
            tx_q      <= 8'h00;
            rx_q      <= 8'h00;
            busy_q    <= 1'b0;
            ack_err_q <= 1'b0;
            done_q    <= 1'b0;
            start_q   <= 1'b0;
            stop_q    <= 1'b0;
            read_q    <= 1'b0;
            nack_q    <= 1'b0;
            scl_oe_q  <= 1'b0;
            sda_oe_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            quarter_q <= quarter_d;
            bit_q     <= bit_d;
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            data_q    <= data_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            busy_q    <= busy_d;
            ack_err_q <= ack_err_d;
            done_q    <= done_d;
            start_q   <= start_d;
            stop_q    <= stop_d;
            read_q    <= read_d;
            nack_q    <= nack_d;
            scl_oe_q  <= scl_oe_d;
            sda_oe_q  <= sda_oe_d;
        end
    end

    always_comb begin
        readdata = 32'd0;
        case (address)
            ADDR_DATA:   readdata = {24'd0, rx_q};
            ADDR_STATUS: readdata = {29'd0, done_q, ack_err_q, busy_q};
            ADDR_DIV:    readdata = {16'd0, div_q};
            default:     readdata = 32'd0;
        endcase
    end

    assign scl_oe = scl_oe_q;
    assign sda_oe = sda_oe_q;
    assign irq    = done_q;

endmodule

// File: tb/tb_audio_nios_i2c_cfg_master.sv
// Bench for audio_nios_i2c_cfg_master: bus monitor + slave model feeding a
// scoreboard of expected START/bit/STOP events, plus register/timing checks.
module tb_audio_nios_i2c_cfg_master;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        scl_oe, sda_oe, scl_in, sda_in, irq;

    int n_checks = 0;
    int n_fails  = 0;
    int cyc      = 0;
    int exp_q[$];

    // Slave: 0 = write with ACK, 1 = write without ACK, 2 = read returning slave_byte
    int         slave_mode   = 0;
    logic [7:0] slave_byte   = 8'h00;
    logic       slave_pull   = 1'b0;
    int         bitcnt       = 0;
    int         stretch_left = 0;
    logic       stretch_arm  = 1'b0;
    logic       scl_prev = 1'b1, sda_prev = 1'b1, oe_prev = 1'b0, cond_seen = 1'b1;

    assign scl_in = ~scl_oe & (stretch_left == 0);
    assign sda_in = ~sda_oe & ~slave_pull;

    audio_nios_i2c_cfg_master dut (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .scl_oe(scl_oe), .sda_oe(sda_oe), .scl_in(scl_in), .sda_in(sda_in), .irq(irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s got=0x%0h exp=0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Bus events: 0/1 = data bit, 2 = START, 3 = STOP
    task automatic sb_pop(input int got);
        if (exp_q.size() == 0) check_eq("bus_unexpected", got, 32'hFFFF_FFFF);
        else check_eq("bus_evt", got, exp_q.pop_front());
    endtask

    task automatic push_byte(input logic [7:0] b, input logic ack);
        for (int i = 7; i >= 0; i--) exp_q.push_back(int'(b[i]));
        exp_q.push_back(int'(ack));
    endtask

    always @(negedge clk) begin
        logic scl_l, sda_l;
        if (reset) begin
            stretch_left = 0;
            stretch_arm  = 1'b0;
            slave_pull   = 1'b0;
            bitcnt       = 0;
            cond_seen    = 1'b1;
            scl_prev     = 1'b1;
            sda_prev     = 1'b1;
            oe_prev      = 1'b0;
        end else begin
            if (stretch_arm && oe_prev && !scl_oe) begin
                stretch_left = 10;
                stretch_arm  = 1'b0;
            end else if (stretch_left > 0) begin
                stretch_left--;
            end
            scl_l = ~scl_oe & (stretch_left == 0);
            sda_l = ~sda_oe & ~slave_pull;
            if (!scl_prev && scl_l) cond_seen = 1'b0;
            if (scl_prev && scl_l && sda_prev && !sda_l) begin
                sb_pop(2);
                cond_seen  = 1'b1;
                bitcnt     = 0;
                slave_pull = 1'b0;
            end else if (scl_prev && scl_l && !sda_prev && sda_l) begin
                sb_pop(3);
                cond_seen  = 1'b1;
                slave_pull = 1'b0;
            end
            if (scl_prev && !scl_l) begin
                if (!cond_seen) begin
                    sb_pop(int'(sda_prev));
                    bitcnt++;
                end
                if (bitcnt == 9) begin
                    bitcnt     = 0;
                    slave_pull = 1'b0;
                end else if (bitcnt == 8) begin
                    slave_pull = (slave_mode == 0);
                end else begin
                    slave_pull = (slave_mode == 2) && !slave_byte[7 - bitcnt];
                end
            end
            scl_prev = scl_l;
            sda_prev = sda_l;
            oe_prev  = scl_oe;
        end
    end

    // Call at (or just after) a negedge; the write lands on the next posedge.
    task automatic avm_write(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic avm_read(input logic [1:0] a, output logic [31:0] d);
        address = a;
        #1;
        d = readdata;
    endtask

    task automatic wait_busy(output int n);
        n = 0;
        address = 2'd2;
        #1;
        while (readdata[0] && n < 5000) begin
            n++;
            @(negedge clk);
            #1;
        end
        if (n >= 5000) check_eq("busy_timeout", 32'(n), 32'd0);
    endtask

    task automatic run_cmd(input logic [7:0] data, input logic [3:0] cmd, input int exp_busy);
        int n;
        avm_write(2'd0, {24'd0, data});
        avm_write(2'd1, {28'd0, cmd});
        wait_busy(n);
        $display("txn cmd=0x%0h data=0x%02h busy_cycles=%0d", cmd, data, n);
        check_eq("busy_cycles", 32'(n), 32'(exp_busy));
        check_eq("sb_drain", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        int c0;
        reset = 1'b1; address = 2'd0; chipselect = 1'b0; write_n = 1'b1; writedata = 32'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        avm_read(2'd2, rd); check_eq("rst_status", rd, 32'd0);
        avm_read(2'd3, rd); check_eq("rst_div", rd, 32'd125);
        avm_read(2'd0, rd); check_eq("rst_rx", rd, 32'd0);
        avm_read(2'd1, rd); check_eq("cmd_reads_0", rd, 32'd0);
        check_eq("rst_oe", {30'd0, scl_oe, sda_oe}, 32'd0);
        check_eq("rst_irq", 32'(irq), 32'd0);
        @(negedge clk);

        // Write 0x34 with START and STOP, slave ACKs
        avm_write(2'd3, 32'd4);
        avm_read(2'd3, rd); check_eq("div_rw", rd, 32'd4);
        slave_mode = 0;
        exp_q.push_back(2); push_byte(8'h34, 1'b0); exp_q.push_back(3);
        run_cmd(8'h34, 4'h3, 168);
        avm_read(2'd2, rd); check_eq("wr_status", rd, 32'h4);
        check_eq("wr_irq", 32'(irq), 32'd1);
        check_eq("wr_bus_free", {30'd0, scl_oe, sda_oe}, 32'd0);

        // Write 0xA5 with START only, slave NACKs; bus left held
        slave_mode = 1;
        exp_q.push_back(2); push_byte(8'hA5, 1'b1);
        run_cmd(8'hA5, 4'h1, 156);
        avm_read(2'd2, rd); check_eq("nack_status", rd, 32'h6);
        check_eq("hold_oe", {30'd0, scl_oe, sda_oe}, 32'h2);

        // Repeated START read of 0xC3 with master ACK and STOP
        slave_mode = 2; slave_byte = 8'hC3;
        exp_q.push_back(2); push_byte(8'hC3, 1'b0); exp_q.push_back(3);
        run_cmd(8'h00, 4'h7, 168);
        avm_read(2'd2, rd); check_eq("rs_status", rd, 32'h4);
        avm_read(2'd0, rd); check_eq("rs_rx", rd, 32'hC3);

        // Read 0x5A with NACK and STOP, no START
        slave_byte = 8'h5A;
        push_byte(8'h5A, 1'b1); exp_q.push_back(3);
        run_cmd(8'h00, 4'hE, 156);
        avm_read(2'd0, rd); check_eq("rd_rx", rd, 32'h5A);
        avm_read(2'd2, rd); check_eq("rd_status", rd, 32'h4);

        // Clock stretch of 10 cycles in bit 0 high quarter
        slave_mode = 0; stretch_arm = 1'b1;
        push_byte(8'h0F, 1'b0);
        run_cmd(8'h0F, 4'h0, 154);
        avm_read(2'd2, rd); check_eq("st_status", rd, 32'h4);

        // Writes while busy, and W1C of done in the done-set cycle
        exp_q.push_back(2); push_byte(8'h96, 1'b0); exp_q.push_back(3);
        @(negedge clk);
        avm_write(2'd0, 32'h96);
        avm_write(2'd1, 32'h3);
        c0 = cyc;
        avm_write(2'd1, 32'h4);
        avm_write(2'd3, 32'd9);
        avm_write(2'd0, 32'hFF);
        avm_read(2'd3, rd); check_eq("div_busy_ignored", rd, 32'd4);
        while (cyc < c0 + 167) @(negedge clk);
        avm_read(2'd2, rd); check_eq("busy_at_167", rd, 32'h1);
        avm_write(2'd2, 32'h4);
        avm_read(2'd2, rd); check_eq("w1c_collide_done", rd, 32'h4);
        $display("txn cmd=0x3 data=0x96 busy_writes_ignored");
        check_eq("sb_drain", 32'(exp_q.size()), 32'd0);
        repeat (20) @(negedge clk);
        avm_read(2'd2, rd); check_eq("cmd_busy_ignored", rd, 32'h4);
        check_eq("idle_oe", {30'd0, scl_oe, sda_oe}, 32'd0);
        @(negedge clk);
        avm_write(2'd2, 32'h6);
        avm_read(2'd2, rd); check_eq("w1c_status", rd, 32'd0);
        check_eq("w1c_irq", 32'(irq), 32'd0);

        // DIV = 0 behaves as 1
        @(negedge clk);
        avm_write(2'd3, 32'd0);
        avm_read(2'd3, rd); check_eq("div0_rw", rd, 32'd0);
        push_byte(8'hC9, 1'b0);
        @(negedge clk);
        run_cmd(8'hC9, 4'h0, 36);

        // Asynchronous reset mid-bit
        @(negedge clk);
        avm_write(2'd3, 32'd4);
        exp_q.push_back(2); push_byte(8'h34, 1'b0); exp_q.push_back(3);
        avm_write(2'd0, 32'h34);
        avm_write(2'd1, 32'h3);
        repeat (30) @(negedge clk);
        #2;
        check_eq("pre_rst_oe", {30'd0, scl_oe, sda_oe}, 32'h3);
        reset = 1'b1;
        #1;
        check_eq("async_rst_oe", {30'd0, scl_oe, sda_oe}, 32'd0);
        check_eq("async_rst_irq", 32'(irq), 32'd0);
        avm_read(2'd2, rd); check_eq("async_rst_status", rd, 32'd0);
        avm_read(2'd3, rd); check_eq("async_rst_div", rd, 32'd125);
        avm_read(2'd0, rd); check_eq("async_rst_rx", rd, 32'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // First command after reset runs normally
        avm_write(2'd3, 32'd4);
        slave_mode = 0;
        exp_q.push_back(2); push_byte(8'h21, 1'b0); exp_q.push_back(3);
        run_cmd(8'h21, 4'h3, 168);
        avm_read(2'd2, rd); check_eq("post_rst_status", rd, 32'h4);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule
